// File: rtl/rr_arb_4_ctrl_pkg.sv
// rtl/rr_arb_4_ctrl_pkg.sv - shared constants and state encoding for the 4-way round-robin arbiter
package rr_arb_4_ctrl_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } arb_state_e;

endpackage

// File: rtl/dec_2to4_en.sv
// rtl/dec_2to4_en.sv - 2-to-4 one-hot decoder with enable; all-zero output when disabled
module dec_2to4_en
    import rr_arb_4_ctrl_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] dec_o
);

    assign dec_o = en_i ? (N_REQ'(1) << idx_i) : '0;

endmodule

// File: rtl/rr_arb_4_ctrl.sv
// rtl/rr_arb_4_ctrl.sv - 4-requester round-robin arbiter (IDLE/GRANT/GAP); RR_ARB_TIMEOUT_EN adds forced rotation
module rr_arb_4_ctrl
    import rr_arb_4_ctrl_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_REQ-1:0] REQ,
    input  logic             DONE,
    output logic [N_REQ-1:0] GNT,
    output logic [IDX_W-1:0] GNT_IDX,
    output logic             GNT_VLD,
    output logic             BUSY
);

    arb_state_e       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] idx_q;
    logic             vld_q;
    logic             busy_q;

    logic [IDX_W-1:0] pick_d;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic             timeout;
    logic             release_d;

    // First requester at or after the pointer, wrapping modulo 4.
    always_comb begin
        pick_d = ptr_q;
        cand   = ptr_q;
        found  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr_q + IDX_W'(i);
            if (!found && REQ[cand]) begin
                pick_d = cand;
                found  = 1'b1;
            end
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_q;
    logic [N_REQ-1:0] others;

    assign others  = REQ & ~(N_REQ'(1) << idx_q);
    assign timeout = (hold_q == CNT_W'(MAX_HOLD - 1)) && (others != '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_q <= '0;
        end else if (state_q == ST_IDLE) begin
            hold_q <= '0;
        end else if (state_q == ST_GRANT && hold_q != '1) begin
            hold_q <= hold_q + 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{MAX_HOLD, CNT_W};
    assign timeout    = 1'b0;
`endif

    assign release_d = DONE || !REQ[idx_q] || timeout;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found) begin
                        idx_q   <= pick_d;
                        vld_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_d) begin
                        vld_q   <= 1'b0;
                        ptr_q   <= idx_q + 1'b1;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    vld_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    dec_2to4_en u_dec (
        .idx_i (idx_q),
        .en_i  (vld_q),
        .dec_o (GNT)
    );

    assign GNT_IDX = idx_q;
    assign GNT_VLD = vld_q;
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_rr_arb_4_ctrl.sv
// tb/tb_rr_arb_4_ctrl.sv - scoreboard bench for rr_arb_4_ctrl; RR_ARB_TIMEOUT_EN selects the timeout checks
module tb_rr_arb_4_ctrl;

    logic       CLK;
    logic       RST_N;
    logic [3:0] REQ;
    logic       DONE;
    logic [3:0] GNT;
    logic [1:0] GNT_IDX;
    logic       GNT_VLD;
    logic       BUSY;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    logic prev_vld = 1'b0;

    rr_arb_4_ctrl #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .REQ     (REQ),
        .DONE    (DONE),
        .GNT     (GNT),
        .GNT_IDX (GNT_IDX),
        .GNT_VLD (GNT_VLD),
        .BUSY    (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_grant(input int bound, output int n);
        n = 0;
        while (!GNT_VLD && n < bound) begin
            tick();
            n++;
        end
        check("wait_grant", int'(GNT_VLD), 1);
    endtask

    task automatic count_hold(input int bound, output int n);
        n = 0;
        while (GNT_VLD && n < bound) begin
            n++;
            tick();
        end
    endtask

    // Scoreboard: every new grant pops the next expected owner.
    always @(posedge CLK) begin
        #1;
        if (GNT_VLD && !prev_vld) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_grant", int'(GNT_IDX), 255);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("sb_idx", int'(GNT_IDX), e);
                check("sb_onehot", int'(GNT), 1 << e);
            end
        end
        prev_vld = GNT_VLD;
    end

    initial begin
        int n;
        RST_N = 1'b0;
        REQ   = 4'b0000;
        DONE  = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;

        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_gnt", int'(GNT), 0);
            check("rst_vld", int'(GNT_VLD), 0);
            check("rst_busy", int'(BUSY), 0);
        end
        check("rst_idx", int'(GNT_IDX), 0);

        // Single requester: one-cycle latency, release, GAP, IDLE.
        REQ = 4'b0100;
        exp_q.push_back(2);
        wait_grant(5, n);
        check("single_latency", n, 1);
        check("single_busy", int'(BUSY), 1);
        tick();
        tick();
        check("single_held", int'(GNT), 4'b0100);
        DONE = 1'b1;
        REQ  = 4'b0000;
        tick();
        DONE = 1'b0;
        check("single_gap_gnt", int'(GNT), 0);
        check("single_gap_busy", int'(BUSY), 1);
        check("single_gap_idx", int'(GNT_IDX), 2);
        tick();
        check("single_idle_busy", int'(BUSY), 0);

        // Pointer is 3: REQ=1001 serves 3 then 0.
        REQ = 4'b1001;
        exp_q.push_back(3);
        exp_q.push_back(0);
        wait_grant(5, n);
        check("wrap_first", int'(GNT_IDX), 3);
        DONE = 1'b1;
        REQ  = 4'b0001;
        tick();
        DONE = 1'b0;
        wait_grant(5, n);
        check("wrap_turnaround", n, 2);

        // Asynchronous reset mid-grant.
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_gnt", int'(GNT), 0);
        check("arst_vld", int'(GNT_VLD), 0);
        check("arst_busy", int'(BUSY), 0);
        REQ = 4'b0000;
        tick();
        RST_N = 1'b1;
        tick();

        // All requesting from pointer 0: 0,1,2,3,0, each with GAP + IDLE.
        REQ = 4'b1111;
        for (int k = 0; k < 5; k++) exp_q.push_back(k % 4);
        for (int k = 0; k < 5; k++) begin
            wait_grant(5, n);
            if (k > 0) check("rr_turnaround", n, 1);
            tick();
            DONE = 1'b1;
            if (k == 4) REQ = 4'b0000;
            tick();
            DONE = 1'b0;
            check("rr_gap_gnt", int'(GNT), 0);
            tick();
            check("rr_idle_gnt", int'(GNT), 0);
            check("rr_idle_busy", int'(BUSY), 0);
        end

        // Pointer is 1: owner drops REQ without DONE.
        REQ = 4'b0010;
        exp_q.push_back(1);
        wait_grant(5, n);
        tick();
        REQ = 4'b0000;
        tick();
        check("drop_gnt", int'(GNT), 0);
        check("drop_busy", int'(BUSY), 1);
        tick();

        // Pointer is 2: grant 1, then DONE and drop together -> one GAP, pointer 2.
        REQ = 4'b0010;
        exp_q.push_back(1);
        wait_grant(5, n);
        DONE = 1'b1;
        REQ  = 4'b0000;
        tick();
        DONE = 1'b0;
        check("both_gap_busy", int'(BUSY), 1);
        tick();
        check("both_single_gap", int'(BUSY), 0);
        REQ = 4'b0111;
        exp_q.push_back(2);
        wait_grant(5, n);
        DONE = 1'b1;
        REQ  = 4'b0000;
        tick();
        DONE = 1'b0;
        tick();

        // Pointer is 3: DONE during IDLE is ignored, non-owner REQ changes ignored.
        REQ  = 4'b1000;
        DONE = 1'b1;
        exp_q.push_back(3);
        wait_grant(5, n);
        DONE = 1'b0;
        tick();
        check("done_idle_ignored", int'(GNT), 4'b1000);
        REQ = 4'b1010;
        tick();
        REQ = 4'b1111;
        tick();
        check("nonowner_ignored", int'(GNT), 4'b1000);
        DONE = 1'b1;
        REQ  = 4'b0000;
        tick();
        DONE = 1'b0;
        tick();

        // Pointer is 0: REQ=0011 with no DONE.
        REQ = 4'b0011;
        exp_q.push_back(0);
        wait_grant(5, n);
`ifdef RR_ARB_TIMEOUT_EN
        count_hold(40, n);
        check("timeout_hold", n, 8);
        REQ = 4'b0010;
        exp_q.push_back(1);
        wait_grant(5, n);
        check("timeout_next_latency", n, 2);
        count_hold(25, n);
        check("alone_hold", n, 25);
`else
        count_hold(30, n);
        check("no_timeout_hold", n, 30);
`endif
        DONE = 1'b1;
        REQ  = 4'b0000;
        tick();
        DONE = 1'b0;
        tick();
        tick();
        check("sb_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arb_4_ctrl.md
Name: rr_arb_4_ctrl

Overview:
- Round-robin arbiter sharing one downstream resource between 4 requesters.
- Registers a 2-bit winner index and drives a one-hot grant through a 2-to-4 decoder with enable. The enable is the grant-valid flag.
- Sits between 4 requesting units and a shared bus or port. It is the sequencing layer above the team's combinational decoder.

Parameters:
- MAX_HOLD, 8, max consecutive grant cycles before forced rotation (timeout feature only). Legal range 1..2^CNT_W-1.
- CNT_W, 4, width of the hold counter.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  reset, asynchronous, active-low.
- REQ  input  4  request per requester; level, held until granted and served.
- DONE  input  1  current owner releases the resource. Sampled only in GRANT.
- GNT  output  4  one-hot grant; all zero when no grant.
- GNT_IDX  output  2  index of current or last owner.
- GNT_VLD  output  1  a grant is active; equals OR of GNT.
- BUSY  output  1  high in GRANT and GAP states.

Behaviour:
- Reset (RST_N=0, immediate, asynchronous):
  - state=IDLE, PTR=0, GNT_IDX=0, GNT=0, GNT_VLD=0, BUSY=0, hold counter=0.
  - Reset mid-grant drops GNT in the same cycle, without waiting for a clock.
- All registers update on the CLK rising edge. GNT is the decoder output of the registered GNT_IDX and GNT_VLD, with no extra combinational path from REQ.
- States: IDLE, GRANT, GAP (2-bit encoding).
- IDLE:
  - If REQ != 0, pick the first set bit scanning PTR, PTR+1, PTR+2, PTR+3 (mod 4).
  - Load GNT_IDX, set GNT_VLD, clear the hold counter, go to GRANT.
  - If REQ == 0, stay in IDLE.
  - Latency: REQ seen at edge n gives GNT at edge n+1 (1 cycle).
- GRANT:
  - GNT = one-hot(GNT_IDX) and the hold counter increments each cycle, saturating at 2^CNT_W-1.
  - Exit to GAP when any of these holds: DONE=1; REQ[GNT_IDX]=0; timeout (see Optional Feature).
  - On exit: GNT_VLD=0, PTR=GNT_IDX+1 mod 4.
  - Simultaneous exit causes are one exit. PTR advances once.
- GAP:
  - Exactly one dead cycle with GNT=0 and BUSY=1, then go to IDLE. This guarantees non-overlapping ownership between consecutive owners.
  - Requests arriving in GAP are held off and arbitrated in IDLE on the next edge. Minimum back-to-back turnaround is: grant, GAP, IDLE, grant.
- Changes to REQ of non-owners during GRANT have no effect on the current grant.
- DONE outside GRANT is ignored.
- Fairness: each requester is granted at most once per 4 consecutive grants while others are pending.
- Invariants: GNT has at most one bit set, and GNT_VLD = |GNT at all times.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, if the hold counter = MAX_HOLD-1 and at least one other REQ bit is set, force exit to GAP and rotate PTR.
  - If no other requester is pending, the grant continues past MAX_HOLD and the counter saturates.
- Undefined:
  - The hold counter and timeout logic are absent. Only DONE or the owner dropping REQ ends a grant.
  - MAX_HOLD and CNT_W are ignored.

Decomposition:
- Shared package/include holds:
  - state encodings: IDLE=2'b00, GRANT=2'b01, GAP=2'b10.
  - requester count constant N_REQ=4.
  - index width constant IDX_W=2.
- One sub-module: dec_2to4_en, a 2-to-4 decoder with enable. Inputs are GNT_IDX and GNT_VLD; output is GNT. It is instantiated once.
- The round-robin next-index search stays inline in the controller.

Test Plan:
- Reset release with REQ=4'b0000 for 5 cycles: GNT=0, GNT_VLD=0, BUSY=0 throughout. Reasserting RST_N=0 mid-grant clears GNT before the next CLK edge.
- Single requester: REQ=4'b0100 at edge 0 gives GNT=4'b0100 and GNT_IDX=2 at edge 1. DONE at edge 4 gives GNT=0 at edge 5 (GAP), then IDLE at edge 6.
- Contention, all requesting: REQ=4'b1111 with each owner pulsing DONE after 2 cycles. Grant order is 0,1,2,3,0, each separated by GAP + IDLE.
- Pointer wrap: PTR=3 after serving requester 2, then REQ=4'b0001 gives GNT_IDX=0. REQ=4'b1001 gives 3 first, then 0.
- Owner drops REQ without DONE: requester 1 granted, REQ[1]=0 at edge k gives GNT=0 at edge k+1. Simultaneous DONE and REQ drop gives a single GAP and PTR=2.
- With RR_ARB_TIMEOUT_EN and MAX_HOLD=8, REQ=4'b0011 with no DONE:
  - requester 0 holds for 8 cycles, then GAP, then requester 1 is granted.
  - With REQ=4'b0001 alone, the grant persists 20+ cycles.
  - Without the macro, requester 0 holds indefinitely.
